debug_serial_tx: RTL

- Serial-port end of the CPU debug channel. Takes the seven 8-bit CPU debug ports and sends them to the host debugger over UART (8N1, LSB first).
- On request, it snapshots all seven ports and sends one framed packet: sync byte, seven data bytes, checksum.
- Sits between the cpu debug_port outputs and the board TX pin.

---
 rtl/debug_serial_tx.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/debug_serial_tx.sv
// debug_serial_tx
//   Serial-port end of the CPU debug channel. On request it snapshots the
//   seven CPU debug bytes and sends one UART (8N1, LSB first) packet:
//   SYNC_BYTE, debug_port1..7, then the mod-256 sum of the seven data bytes.
//
// Ports
//   clk          system clock, rising edge
//   nreset       synchronous active-low reset
//   frame_req    starts a frame when sampled high while busy is low
//   debug_port1..debug_port7  CPU debug bytes, captured at frame acceptance
//   txd          UART serial output, idles high
//   busy         high while a frame is in flight
//   frame_done   one-cycle pulse after the last stop bit of a frame
module debug_serial_tx #(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       frame_req,
  input  logic [7:0] debug_port1,
  input  logic [7:0] debug_port2,
  input  logic [7:0] debug_port3,
  input  logic [7:0] debug_port4,
  input  logic [7:0] debug_port5,
  input  logic [7:0] debug_port6,
  input  logic [7:0] debug_port7,
  output logic       txd,
  output logic       busy,
  output logic       frame_done
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  BAUD_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] baud_cnt, baud_nxt;
  logic [3:0]       byte_idx, byte_nxt;
  logic [2:0]       bit_idx, bit_nxt;
  logic             done_nxt;
  logic             load;
  logic             bit_end;
  logic [6:0][7:0]  snap;
  logic [7:0]       cur_byte;

  // Mod-256 sum of the snapshotted data bytes; the sync byte is not included.
  function automatic logic [7:0] checksum(input logic [6:0][7:0] b);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < 7; i++) s = s + b[i];
    return s;
  endfunction

  assign bit_end = (baud_cnt == BAUD_MAX);
  assign busy    = (state != IDLE);

  // Byte selected for transmission by the frame position.
  always_comb begin
    case (byte_idx)
      4'd0:    cur_byte = SYNC_BYTE;
      4'd1:    cur_byte = snap[0];
      4'd2:    cur_byte = snap[1];
      4'd3:    cur_byte = snap[2];
      4'd4:    cur_byte = snap[3];
      4'd5:    cur_byte = snap[4];
      4'd6:    cur_byte = snap[5];
      4'd7:    cur_byte = snap[6];
      default: cur_byte = checksum(snap);
    endcase
  end

  always_comb begin
    case (state)
      START:   txd = 1'b0;
      DATA:    txd = cur_byte[bit_idx];
      default: txd = 1'b1;
    endcase
  end

  // Next-state logic; bit timing runs off the shared baud counter.
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    byte_nxt  = byte_idx;
    bit_nxt   = bit_idx;
    done_nxt  = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (frame_req) begin
          load      = 1'b1;
          state_nxt = START;
          baud_nxt  = '0;
          byte_nxt  = 4'd0;
          bit_nxt   = 3'd0;
        end
      end
      START: begin
        if (bit_end) begin
          baud_nxt  = '0;
          bit_nxt   = 3'd0;
          state_nxt = DATA;
        end else begin
          baud_nxt  = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_nxt = '0;
          if (bit_idx == 3'd7) begin
            bit_nxt   = 3'd0;
            state_nxt = STOP;
          end else begin
            bit_nxt   = bit_idx + 3'd1;
          end
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_nxt = '0;
          if (byte_idx == 4'd8) begin
            byte_nxt  = 4'd0;
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            byte_nxt  = byte_idx + 4'd1;
            state_nxt = START;
          end
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      byte_idx   <= 4'd0;
      bit_idx    <= 3'd0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      baud_cnt   <= baud_nxt;
      byte_idx   <= byte_nxt;
      bit_idx    <= bit_nxt;
      frame_done <= done_nxt;
    end
  end

  // Snapshot is pure data: loaded on acceptance, never reset.
  always_ff @(posedge clk) begin
    if (load) begin
      snap <= {debug_port7, debug_port6, debug_port5, debug_port4,
               debug_port3, debug_port2, debug_port1};
    end
  end

endmodule
